// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit.
// Multiply is shift-add on operand magnitudes and divide is restoring division
// on magnitudes. Each takes WIDTH iteration edges plus one edge that applies
// the sign and selects the result. Latency is therefore WIDTH+1 edges for
// every operation.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int              CW         = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Two's-complement negation at operand width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation at product width.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t               state_r;
    logic                 busy_r, done_r;
    logic [WIDTH-1:0]     result_r;
    logic [CW-1:0]        count_r;
    logic [2:0]           op_r;
    logic [WIDTH-1:0]     a_r;
    logic                 a_neg_r, b_neg_r;
    logic [WIDTH-1:0]     a_mag_r, b_mag_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [WIDTH-1:0]     quot_r;
    logic [WIDTH-1:0]     rem_r;

    logic                 a_signed_s, b_signed_s;
    logic                 a_neg_s, b_neg_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH:0]       div_diff_s;
    logic                 div_ge_s;
    logic [2*WIDTH-1:0]   prod_fin_s;
    logic [WIDTH-1:0]     quot_fin_s, rem_fin_s;
    logic                 b_zero_s;
    logic [WIDTH-1:0]     fin_s;

    // Operand signedness per funct3, and magnitudes of the incoming operands.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'b010: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        a_neg_s = a_signed_s & a[WIDTH-1];
        b_neg_s = b_signed_s & b[WIDTH-1];
        a_mag_s = a_neg_s ? neg_w(a) : a;
        b_mag_s = b_neg_s ? neg_w(b) : b;
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                    + (prod_r[0] ? {1'b0, a_mag_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {rem_r, quot_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_mag_r});
        div_diff_s  = div_shift_s - {1'b0, b_mag_r};
    end

    // Sign application, special cases and result selection after the last iteration.
    always_comb begin
        prod_fin_s = (a_neg_r ^ b_neg_r) ? neg_2w(prod_r) : prod_r;
        quot_fin_s = (a_neg_r ^ b_neg_r) ? neg_w(quot_r) : quot_r;
        rem_fin_s  = a_neg_r ? neg_w(rem_r) : rem_r;
        b_zero_s   = (b_mag_r == ZERO_W);
        case (op_r)
            3'b000:                 fin_s = prod_fin_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin_s = prod_fin_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fin_s = b_zero_s ? ONES_W : quot_fin_s;
            3'b110, 3'b111:         fin_s = b_zero_s ? a_r : rem_fin_s;
            default:                fin_s = ZERO_W;
        endcase
    end

    // Control FSM with datapath registers; reset discards any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO_W;
            count_r  <= {CW{1'b0}};
            op_r     <= 3'b000;
            a_r      <= ZERO_W;
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
            a_mag_r  <= ZERO_W;
            b_mag_r  <= ZERO_W;
            prod_r   <= {(2*WIDTH){1'b0}};
            quot_r   <= ZERO_W;
            rem_r    <= ZERO_W;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                        count_r <= {CW{1'b0}};
                        op_r    <= funct3;
                        a_r     <= a;
                        a_neg_r <= a_neg_s;
                        b_neg_r <= b_neg_s;
                        a_mag_r <= a_mag_s;
                        b_mag_r <= b_mag_s;
                        prod_r  <= {ZERO_W, b_mag_s};
                        quot_r  <= a_mag_s;
                        rem_r   <= ZERO_W;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                CALC: begin
                    if (count_r != LAST_COUNT) begin
                        count_r <= count_r + CNT_ONE;
                        if (op_r[2]) begin
                            rem_r  <= div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
                            quot_r <= {quot_r[WIDTH-2:0], div_ge_s};
                        end else begin
                            prod_r <= {mul_sum_s, prod_r[WIDTH-1:1]};
                        end
                    end else begin
                        state_r  <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= fin_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a scoreboard of expected results and
// done cycles for a WIDTH=32 instance, plus a WIDTH=8 instance for short checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    logic        start8;
    logic [2:0]  funct3_8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  result8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];
    int          due_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .funct3(funct3_8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(result8)
    );

    always #5 clk = ~clk;

    // Edge counter: after k rising edges cyc equals k.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model built on native 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'({32'h0, y}); return p[63:32]; end
            3'd3: begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
            3'd4: begin if (y == 32'h0) return 32'hFFFF_FFFF; q = sx / sy; return q[31:0]; end
            3'd5: begin if (y == 32'h0) return 32'hFFFF_FFFF; return x / y; end
            3'd6: begin if (y == 32'h0) return x; q = sx % sy; return q[31:0]; end
            default: begin if (y == 32'h0) return x; return x % y; end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one operation (called #1 after an edge); records expectation.
    task automatic launch(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [31:0] expv);
        funct3 = f; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        funct3 = 3'($urandom_range(0, 7));
        exp_q.push_back(expv);
        due_q.push_back(cyc + 33);
    endtask

    // Wait for done (bounded) and compare against the scoreboard head.
    task automatic wait_done(input string tag);
        int          n;
        logic [31:0] e;
        int          d;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            if (n >= 100) begin
                check({tag, " timeout"}, {31'b0, done}, 32'd1);
            end else begin
                check({tag, " result"}, result, e);
                check({tag, " cycle"}, 32'(cyc), 32'(d));
                check({tag, " busy@done"}, {31'b0, busy}, 32'd0);
            end
        end
    endtask

    task automatic run8(input string tag, input logic [2:0] f, input logic [7:0] x, input logic [7:0] y, input logic [7:0] expv);
        int n0, n;
        funct3_8 = f; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n0 = cyc;
        n = 0;
        while (done8 !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " result"}, 32'(result8), 32'(expv));
        check({tag, " cycle"}, 32'(cyc), 32'(n0 + 9));
    endtask

    logic [2:0]  dir_f[11]   = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] dir_a[11]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'd10, 32'd10, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] dir_b[11]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] dir_e[11]   = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'h0000_000A, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          n0;

        reset = 1'b1; start = 1'b0; funct3 = 3'd0; a = 32'd0; b = 32'd0;
        start8 = 1'b0; funct3_8 = 3'd0; a8 = 8'd0; b8 = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // MUL 7*6 with busy/done timing probes.
        launch(3'd0, 32'd7, 32'd6, 32'h0000_002A);
        n0 = cyc;
        check("mul busy first", {31'b0, busy}, 32'd1);
        repeat (32) @(posedge clk);
        #1;
        check("mul busy last", {31'b0, busy}, 32'd1);
        check("mul done early", {31'b0, done}, 32'd0);
        check("mul cyc probe", 32'(cyc), 32'(n0 + 32));
        wait_done("mul7x6");
        @(posedge clk); #1;
        check("done pulse width", {31'b0, done}, 32'd0);
        check("result hold", result, 32'h0000_002A);

        // Directed multiply/divide boundary cases.
        for (int i = 0; i < 11; i++) begin
            launch(dir_f[i], dir_a[i], dir_b[i], dir_e[i]);
            wait_done($sformatf("dir%0d", i));
        end
        launch(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("mul minint");

        // Random operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            launch(rf, ra, rb, model(rf, ra, rb));
            wait_done($sformatf("rnd%0d f%0d", i, rf));
        end

        // start pulsed mid-CALC is ignored.
        launch(3'd5, 32'd1000, 32'd7, 32'd142);
        repeat (5) @(posedge clk);
        #1;
        funct3 = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore start");

        // Back-to-back: start held in the DONE cycle.
        launch(3'd0, 32'd12, 32'd12, 32'd144);
        wait_done("b2b first");
        launch(3'd7, 32'd100, 32'd7, 32'd2);
        check("b2b no idle", {31'b0, busy}, 32'd1);
        wait_done("b2b second");

        // Reset during DIVU, with start also high at the reset edge.
        launch(3'd5, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b1; funct3 = 3'd0; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        exp_q.delete();
        due_q.delete();
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst result", result, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst stays idle", {31'b0, busy}, 32'd0);
        launch(3'd0, 32'd5, 32'd5, 32'd25);
        wait_done("after reset");

        // WIDTH=8 instance.
        run8("w8 divu", 3'd5, 8'd200, 8'd7, 8'd28);
        run8("w8 div ovf", 3'd4, 8'h80, 8'hFF, 8'h80);
        run8("w8 mulh", 3'd1, 8'h80, 8'h80, 8'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal values are even and 8..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 funct3  input  3  RV M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a  input  WIDTH  operand rs1.
REQ-007 b  input  WIDTH  operand rs2.
REQ-008 busy  output  1  high while an operation is in progress (CALC state).
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result  output  WIDTH  registered result.

Function
REQ-011 FSM states are IDLE, CALC and DONE; the FSM has no other reachable states.
REQ-012 In IDLE or DONE, start=1 at edge N latches a, b and funct3 and moves the FSM to CALC; a, b and funct3 are ignored at every other time.
REQ-013 start in CALC is ignored, with no queuing and no effect on the operation in progress.
REQ-014 CALC runs exactly WIDTH iteration edges, tracked by a counter of $clog2(WIDTH)+1 bits, then goes to DONE; done is high in the cycle after edge N+WIDTH+1.
REQ-015 Latency is fixed at WIDTH+1 edges for every funct3, including the special cases.
REQ-016 busy=1 exactly while in CALC; done=1 exactly while in DONE.
REQ-017 DONE lasts one cycle, then goes to IDLE, or to CALC if start=1, giving back-to-back operations.
REQ-018 result updates only on entry to DONE and holds until the next entry to DONE or reset.
REQ-019 Multiply uses iterative shift-add on operand magnitudes, one bit per iteration, with a 2*WIDTH-bit product register.
REQ-020 Sign is applied after the last iteration.
REQ-021 Multiply signedness: MUL and MULH treat a and b as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
REQ-022 Multiply result select: MUL returns the low WIDTH bits of the product; MULH, MULHSU and MULHU return the high WIDTH bits of the exact 2*WIDTH-bit product.
REQ-023 Divide uses restoring division on magnitudes, one quotient bit per iteration.
REQ-024 DIV and REM are signed; quotient truncates toward zero and the remainder takes the sign of a.
REQ-025 Divide by zero (b=0): DIV/DIVU return all ones; REM/REMU return a.
REQ-026 Signed overflow (a=-2^(WIDTH-1), b=-1): DIV returns a; REM returns 0.
REQ-027 All arithmetic is modulo 2^WIDTH on the result; no exceptions or flags are produced.

Reset
REQ-028 reset=1 at any edge forces IDLE, busy=0, done=0, result=0, clears the counter, product and quotient registers, and discards any operation in progress.
REQ-029 reset has priority over start at the same edge.
REQ-030 After reset is released, the first start is accepted with normal latency.

Verification (WIDTH=32 unless stated)
REQ-031 MUL a=7, b=6, start at edge N -> busy high through 32 CALC cycles; done pulse one cycle after edge N+33; result=0x0000002A.
REQ-032 MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-033 DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=10, b=0 -> 0xFFFFFFFF; REMU a=10, b=0 -> 0x0000000A; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-034 start pulsed with new operands mid-CALC -> ignored; the first result is delivered unchanged at the original cycle.
REQ-035 start held high in the DONE cycle -> next operation accepted with no IDLE cycle; second done occurs WIDTH+1 edges later.
REQ-036 reset asserted at iteration 10 of a DIVU -> next cycle busy=0, done=0, result=0; with WIDTH=8, DIVU 200/7 -> 28 after 9 edges.
